// File: rtl/dcs_pkg.sv
// Shared constants and types for the DCSformer feeder slice.
package dcs_pkg;

   localparam int unsigned ROWS        = 8;
   localparam int unsigned COLS        = 16;
   localparam int unsigned NW          = 8;
   localparam int unsigned DW          = 8;
   localparam int unsigned MAT_BYTES   = ROWS * COLS;
   localparam int unsigned FRAME_BYTES = MAT_BYTES + NW;
   localparam int unsigned IDX_W       = $clog2(FRAME_BYTES);
   localparam int unsigned RD_W        = $clog2(MAT_BYTES);

   typedef logic [DW-1:0]    byte_t;
   typedef logic [IDX_W-1:0] idx_t;

   typedef enum logic [2:0] {
      LOAD,
      SEND_I,
      WAIT_W,
      SEND_W,
      WAIT_OUT
   } feeder_state_t;

endpackage

// File: rtl/dcs_feeder_if.sv
// Host byte stream, core handshake and status signals of the feeder.
interface dcs_feeder_if;
   import dcs_pkg::*;

   logic  h_valid;
   byte_t h_data;
   logic  h_ready;
   logic  i_valid;
   byte_t i_data;
   logic  w_ready;
   logic  w_valid;
   byte_t w_data;
   logic  o_valid;
   logic  busy;
   logic  frame_done;
   logic  err;

   modport master (
      input  h_valid, h_data, w_ready, o_valid,
      output h_ready, i_valid, i_data, w_valid, w_data, busy, frame_done, err
   );

   modport slave (
      output h_valid, h_data, w_ready, o_valid,
      input  h_ready, i_valid, i_data, w_valid, w_data, busy, frame_done, err
   );

endinterface

// File: rtl/dcs_frame_buf.sv
// 136-byte frame store: one write port, one registered read port, no reset.
module dcs_frame_buf
   import dcs_pkg::*;
(
   input  logic  clk,
   input  logic  we,
   input  idx_t  wr_idx,
   input  byte_t wr_data,
   input  idx_t  rd_idx,
   output byte_t rd_data
);

   byte_t mem [FRAME_BYTES];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[wr_idx] <= wr_data;
      end
      rd_data <= mem[rd_idx];
   end

endmodule

// File: rtl/dcs_feeder.sv
// Buffers one host frame and replays it into the DCSformer core with its burst timing.
module dcs_feeder
   import dcs_pkg::*;
#(
   parameter int unsigned W_TIMEOUT = 64
) (
   input logic          clk,
   input logic          rst,
   dcs_feeder_if.master bus
);

   localparam int unsigned TW = $clog2(W_TIMEOUT);
   localparam int unsigned OW = $clog2(NW);

   feeder_state_t   state, state_n;
   idx_t            wr_idx, wr_idx_n, rd_addr;
   logic [RD_W-1:0] rd_idx, rd_idx_n;
   logic [TW-1:0]   t_cnt, t_cnt_n;
   logic [OW-1:0]   out_cnt, out_cnt_n;
   logic            i_valid_n, w_valid_n, frame_done_n, err_n;
   byte_t           i_data_n, w_data_n, rd_data;
   logic            h_ready, accept;

   assign h_ready     = (state == LOAD) && !rst;
   assign accept      = h_ready && bus.h_valid;
   assign bus.h_ready = h_ready;
   assign bus.busy    = (state != LOAD);

   dcs_frame_buf u_buf (
      .clk     (clk),
      .we      (accept),
      .wr_idx  (wr_idx),
      .wr_data (bus.h_data),
      .rd_idx  (rd_addr),
      .rd_data (rd_data)
   );

   // rd_data always holds the byte after the one being driven, so rd_addr
   // runs two ahead of rd_idx and is parked on the next burst's first byte.
   always_comb begin
      state_n      = state;
      wr_idx_n     = wr_idx;
      rd_idx_n     = rd_idx;
      t_cnt_n      = t_cnt;
      out_cnt_n    = out_cnt;
      i_valid_n    = 1'b0;
      i_data_n     = '0;
      w_valid_n    = 1'b0;
      w_data_n     = '0;
      frame_done_n = 1'b0;
      err_n        = bus.err;
      rd_addr      = '0;
      unique case (state)
         LOAD: begin
            if (accept) begin
               wr_idx_n = wr_idx + 1'b1;
               if (wr_idx == idx_t'(FRAME_BYTES - 1)) begin
                  wr_idx_n  = '0;
                  rd_idx_n  = '0;
                  rd_addr   = idx_t'(1);
                  i_valid_n = 1'b1;
                  i_data_n  = rd_data;
                  state_n   = SEND_I;
               end
            end
         end
         SEND_I: begin
            if (rd_idx == RD_W'(MAT_BYTES - 1)) begin
               rd_idx_n = '0;
               t_cnt_n  = '0;
               rd_addr  = idx_t'(MAT_BYTES);
               state_n  = WAIT_W;
            end else begin
               i_valid_n = 1'b1;
               i_data_n  = rd_data;
               rd_idx_n  = rd_idx + 1'b1;
               rd_addr   = idx_t'(rd_idx) + idx_t'(2);
            end
         end
         WAIT_W: begin
            if (bus.w_ready) begin
               w_valid_n = 1'b1;
               w_data_n  = rd_data;
               rd_idx_n  = '0;
               rd_addr   = idx_t'(MAT_BYTES + 1);
               state_n   = SEND_W;
            end else if (t_cnt == TW'(W_TIMEOUT - 1)) begin
               err_n   = 1'b1;
               state_n = LOAD;
            end else begin
               t_cnt_n = t_cnt + 1'b1;
               rd_addr = idx_t'(MAT_BYTES);
            end
         end
         SEND_W: begin
            if (rd_idx == RD_W'(NW - 1)) begin
               out_cnt_n = '0;
               state_n   = WAIT_OUT;
            end else begin
               w_valid_n = 1'b1;
               w_data_n  = rd_data;
               rd_idx_n  = rd_idx + 1'b1;
               if (rd_idx < RD_W'(NW - 2)) begin
                  rd_addr = idx_t'(MAT_BYTES + 2) + idx_t'(rd_idx);
               end
            end
         end
         WAIT_OUT: begin
            if (bus.o_valid) begin
               if (out_cnt == OW'(NW - 1)) begin
                  out_cnt_n    = '0;
                  frame_done_n = 1'b1;
                  state_n      = LOAD;
               end else begin
                  out_cnt_n = out_cnt + 1'b1;
               end
            end
         end
         default: state_n = LOAD;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= LOAD;
         wr_idx         <= '0;
         rd_idx         <= '0;
         t_cnt          <= '0;
         out_cnt        <= '0;
         bus.i_valid    <= 1'b0;
         bus.i_data     <= '0;
         bus.w_valid    <= 1'b0;
         bus.w_data     <= '0;
         bus.frame_done <= 1'b0;
         bus.err        <= 1'b0;
      end else begin
         state          <= state_n;
         wr_idx         <= wr_idx_n;
         rd_idx         <= rd_idx_n;
         t_cnt          <= t_cnt_n;
         out_cnt        <= out_cnt_n;
         bus.i_valid    <= i_valid_n;
         bus.i_data     <= i_data_n;
         bus.w_valid    <= w_valid_n;
         bus.w_data     <= w_data_n;
         bus.frame_done <= frame_done_n;
         bus.err        <= err_n;
      end
   end

endmodule

// File: tb/tb_dcs_feeder.sv
// Scenario bench for dcs_feeder: host bytes feed a scoreboard drained by the core-side bursts.
module tb_dcs_feeder;
   import dcs_pkg::*;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   dcs_feeder_if bus ();

   dcs_feeder #(.W_TIMEOUT(64)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int    tests = 0;
   int    fails = 0;
   byte_t frame [FRAME_BYTES];
   byte_t iq [$];
   byte_t wq [$];

   // Drives one frame from the host; returns right after the posedge taking byte 135.
   task automatic load_frame(input int gap_every, input bit spur_o);
      int idx = 0;
      int cyc = 0;
      bit gap, rdy;
      bit early = 1'b0;
      while (idx < int'(FRAME_BYTES) && cyc < 1000) begin
         @(negedge clk);
         if (bus.i_valid !== 1'b0 || bus.busy !== 1'b0 || bus.frame_done !== 1'b0) early = 1'b1;
         gap = (gap_every != 0) && ((cyc % gap_every) == gap_every - 1);
         bus.h_valid = !gap;
         bus.h_data  = frame[idx];
         bus.o_valid = spur_o && ((cyc % 2) == 1);
         rdy = bus.h_ready;
         @(posedge clk);
         if (!gap && rdy) begin
            if (idx < int'(MAT_BYTES)) iq.push_back(frame[idx]);
            else wq.push_back(frame[idx]);
            idx++;
         end
         cyc++;
      end
      tests++;
      if (idx != int'(FRAME_BYTES) || early) begin
         fails++;
         $display("FAIL load: accepted %0d bytes (early activity %0d), required %0d bytes and none", idx, early, FRAME_BYTES);
      end
   endtask

   task automatic drain_i(input int n, input int spur_at);
      byte_t want;
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         if (k == 0) begin
            bus.h_valid = 1'b0;
            bus.o_valid = 1'b0;
            tests++;
            if (bus.h_ready !== 1'b0) begin
               fails++;
               $display("FAIL h_ready_drop: got %b, required 0", bus.h_ready);
            end
         end
         bus.w_ready = (k == spur_at);
         want = (iq.size() != 0) ? iq.pop_front() : 8'hxx;
         tests++;
         if (bus.i_valid !== 1'b1 || bus.i_data !== want) begin
            fails++;
            $display("FAIL i_data[%0d]: valid %b data %h, required valid 1 data %h", k, bus.i_valid, bus.i_data, want);
         end
      end
      if (n == int'(MAT_BYTES)) begin
         @(negedge clk);
         bus.w_ready = 1'b0;
         tests++;
         if (bus.i_valid !== 1'b0 || bus.i_data !== 8'h00) begin
            fails++;
            $display("FAIL i_end: valid %b data %h, required 0 00", bus.i_valid, bus.i_data);
         end
      end
   endtask

   task automatic play_core(input int w_delay, input int o_gap);
      byte_t want;
      bit bad = 1'b0;
      bus.w_ready = 1'b0;
      repeat (w_delay) begin
         @(negedge clk);
         if (bus.w_valid !== 1'b0) bad = 1'b1;
      end
      tests++;
      if (bad) begin
         fails++;
         $display("FAIL w_early: w_valid seen before w_ready, required none");
      end
      bus.w_ready = 1'b1;
      @(negedge clk);
      bus.w_ready = 1'b0;
      for (int j = 0; j < int'(NW); j++) begin
         if (j > 0) @(negedge clk);
         want = (wq.size() != 0) ? wq.pop_front() : 8'hxx;
         tests++;
         if (bus.w_valid !== 1'b1 || bus.w_data !== want) begin
            fails++;
            $display("FAIL w_data[%0d]: valid %b data %h, required valid 1 data %h", j, bus.w_valid, bus.w_data, want);
         end
      end
      @(negedge clk);
      tests++;
      if (bus.w_valid !== 1'b0 || bus.w_data !== 8'h00) begin
         fails++;
         $display("FAIL w_end: valid %b data %h, required 0 00", bus.w_valid, bus.w_data);
      end
      for (int s = 0; s < int'(NW); s++) begin
         bus.o_valid = 1'b1;
         @(negedge clk);
         bus.o_valid = 1'b0;
         tests++;
         if (s < int'(NW) - 1) begin
            if (bus.frame_done !== 1'b0) begin
               fails++;
               $display("FAIL fd_early[%0d]: frame_done %b, required 0", s, bus.frame_done);
            end
            repeat (o_gap - 1) @(negedge clk);
         end else if (bus.frame_done !== 1'b1 || bus.h_ready !== 1'b1 || bus.busy !== 1'b0) begin
            fails++;
            $display("FAIL frame_done: fd %b h_ready %b busy %b, required 1 1 0", bus.frame_done, bus.h_ready, bus.busy);
         end
      end
      @(negedge clk);
      tests++;
      if (bus.frame_done !== 1'b0) begin
         fails++;
         $display("FAIL fd_pulse: frame_done %b on second cycle, required 0", bus.frame_done);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      tests++;
      if (bus.h_ready !== 1'b0 || bus.i_valid !== 1'b0 || bus.w_valid !== 1'b0 || bus.busy !== 1'b0 ||
          bus.frame_done !== 1'b0 || bus.err !== 1'b0 || bus.i_data !== 8'h00 || bus.w_data !== 8'h00) begin
         fails++;
         $display("FAIL reset: hr %b iv %b wv %b busy %b fd %b err %b id %h wd %h, required all 0",
                  bus.h_ready, bus.i_valid, bus.w_valid, bus.busy, bus.frame_done, bus.err, bus.i_data, bus.w_data);
      end
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      tests++;
      if (bus.h_ready !== 1'b1) begin
         fails++;
         $display("FAIL reset_release: h_ready %b, required 1", bus.h_ready);
      end
   endtask

   task automatic test_basic();
      for (int i = 0; i < int'(FRAME_BYTES); i++)
         frame[i] = (i < int'(MAT_BYTES)) ? byte_t'(i) : byte_t'(i - int'(MAT_BYTES) + 1);
      load_frame(0, 1'b0);
      drain_i(int'(MAT_BYTES), -1);
      play_core(3, 1);
   endtask

   task automatic test_gaps();
      load_frame(3, 1'b0);
      drain_i(int'(MAT_BYTES), -1);
      play_core(0, 1);
   endtask

   task automatic test_back_to_back();
      load_frame(0, 1'b0);
      drain_i(int'(MAT_BYTES), -1);
      play_core(1, 2);
      for (int i = 0; i < int'(FRAME_BYTES); i++) frame[i] = 8'hFF;
      load_frame(0, 1'b0);
      drain_i(int'(MAT_BYTES), -1);
      play_core(2, 1);
   endtask

   task automatic test_spurious();
      for (int i = 0; i < int'(FRAME_BYTES); i++) frame[i] = byte_t'(i * 7 + 3);
      load_frame(2, 1'b1);
      drain_i(int'(MAT_BYTES), 10);
      play_core(5, 1);
   endtask

   task automatic test_timeout();
      bit bad = 1'b0;
      for (int i = 0; i < int'(FRAME_BYTES); i++) frame[i] = byte_t'(i) ^ 8'h5A;
      load_frame(0, 1'b0);
      drain_i(int'(MAT_BYTES), -1);
      repeat (63) begin
         @(negedge clk);
         if (bus.err !== 1'b0 || bus.w_valid !== 1'b0) bad = 1'b1;
      end
      tests++;
      if (bad) begin
         fails++;
         $display("FAIL timeout_early: err or w_valid raised before 64 idle cycles, required 0");
      end
      @(negedge clk);
      tests++;
      if (bus.err !== 1'b1 || bus.h_ready !== 1'b1 || bus.busy !== 1'b0 || bus.w_valid !== 1'b0) begin
         fails++;
         $display("FAIL timeout: err %b h_ready %b busy %b w_valid %b, required 1 1 0 0", bus.err, bus.h_ready, bus.busy, bus.w_valid);
      end
      wq.delete();
      for (int i = 0; i < int'(FRAME_BYTES); i++) frame[i] = byte_t'(200 - i);
      load_frame(0, 1'b0);
      drain_i(int'(MAT_BYTES), -1);
      play_core(4, 1);
      tests++;
      if (bus.err !== 1'b1) begin
         fails++;
         $display("FAIL err_sticky: err %b, required 1", bus.err);
      end
   endtask

   task automatic test_reset_mid();
      for (int i = 0; i < int'(FRAME_BYTES); i++) frame[i] = byte_t'(255 - i);
      load_frame(0, 1'b0);
      drain_i(51, -1);
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      tests++;
      if (bus.i_valid !== 1'b0 || bus.i_data !== 8'h00 || bus.busy !== 1'b0 || bus.h_ready !== 1'b1 || bus.err !== 1'b0) begin
         fails++;
         $display("FAIL reset_mid: iv %b id %h busy %b hr %b err %b, required 0 00 0 1 0",
                  bus.i_valid, bus.i_data, bus.busy, bus.h_ready, bus.err);
      end
      iq.delete();
      wq.delete();
      for (int i = 0; i < int'(FRAME_BYTES); i++) frame[i] = byte_t'(i * 3 + 1);
      load_frame(0, 1'b0);
      drain_i(int'(MAT_BYTES), -1);
      play_core(0, 2);
   endtask

   initial begin
      rst         = 1'b1;
      bus.h_valid = 1'b0;
      bus.h_data  = '0;
      bus.w_ready = 1'b0;
      bus.o_valid = 1'b0;
      test_reset();
      test_basic();
      test_gaps();
      test_back_to_back();
      test_spurious();
      test_timeout();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, required run to complete");
      $fatal(1);
   end

endmodule
